// File: rtl/ram32x4_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram32x4_arbiter_if
// Brief    : Requester A/B handshake and RAM-side bus of the ram32x4 arbiter.
// Revision : 1.0
// ============================================================================
interface ram32x4_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              req_a;
  logic              wr_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              wr_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic              busy;

  modport slave (
    input  req_a, wr_a, addr_a, wdata_a,
    input  req_b, wr_b, addr_b, wdata_b,
    input  ram_q,
    output ack_a, rdata_a, ack_b, rdata_b,
    output ram_address, ram_data, ram_wren, busy
  );

  modport master (
    output req_a, wr_a, addr_a, wdata_a,
    output req_b, wr_b, addr_b, wdata_b,
    output ram_q,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  ram_address, ram_data, ram_wren, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram32x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram32x4_arbiter
// Brief    : Round-robin two-requester sequencer in front of one ram32x4.
//            Define RAM_ARB_CLEAR_EN to zero the RAM after every reset.
// Revision : 1.0
// ============================================================================
module ram32x4_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  wire logic          clock,
  input  wire logic          resetn,
  ram32x4_arbiter_if.slave   bus
);

  localparam logic c_SEL_A = 1'b0;
  localparam logic c_SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    RDWAIT = 3'd2,
    DONE   = 3'd3
`ifdef RAM_ARB_CLEAR_EN
    ,CLEAR = 3'd4
`endif
  } state_t;

  state_t            r_state;
  logic              r_sel;
  logic              r_last;
  logic              r_wr;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_wren;
  logic              r_ack_a;
  logic              r_ack_b;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_busy;
`ifdef RAM_ARB_CLEAR_EN
  logic              r_clr_pend;
`endif

  // A requester is still holding req during its own ack cycle; that is not a new request.
  wire logic w_elig_a = bus.req_a & ~r_ack_a;
  wire logic w_elig_b = bus.req_b & ~r_ack_b;
  wire logic w_any    = w_elig_a | w_elig_b;
  wire logic w_win_b  = w_elig_b & (~w_elig_a | (r_last == c_SEL_A));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_sel         <= c_SEL_A;
      r_last        <= c_SEL_B;
      r_wr          <= 1'b0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
      r_rdata_a     <= '0;
      r_rdata_b     <= '0;
      r_busy        <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
      r_clr_pend    <= 1'b1;
`endif
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef RAM_ARB_CLEAR_EN
          if (r_clr_pend) begin
            r_clr_pend    <= 1'b0;
            r_state       <= CLEAR;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b1;
            r_busy        <= 1'b1;
          end else
`endif
          if (w_any) begin
            r_sel         <= w_win_b;
            r_last        <= w_win_b;
            r_wr          <= w_win_b ? bus.wr_b    : bus.wr_a;
            r_ram_address <= w_win_b ? bus.addr_b  : bus.addr_a;
            r_ram_data    <= w_win_b ? bus.wdata_b : bus.wdata_a;
            r_ram_wren    <= w_win_b ? bus.wr_b    : bus.wr_a;
            r_state       <= ISSUE;
            r_busy        <= 1'b1;
          end else begin
            r_ram_wren <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ISSUE: begin
          r_ram_wren <= 1'b0;
          r_state    <= r_wr ? DONE : RDWAIT;
        end
        RDWAIT: begin
          if (r_sel == c_SEL_B) r_rdata_b <= bus.ram_q;
          else                  r_rdata_a <= bus.ram_q;
          r_state <= DONE;
        end
        DONE: begin
          r_ack_a <= (r_sel == c_SEL_A);
          r_ack_b <= (r_sel == c_SEL_B);
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
`ifdef RAM_ARB_CLEAR_EN
        CLEAR: begin
          // The address register doubles as the clear counter.
          if (r_ram_address == {ADDR_W{1'b1}}) begin
            r_ram_wren <= 1'b0;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else begin
            r_ram_address <= r_ram_address + 1'b1;
          end
        end
`endif
        default: begin
          r_ram_wren <= 1'b0;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_a       = r_ack_a;
  assign bus.ack_b       = r_ack_b;
  assign bus.rdata_a     = r_rdata_a;
  assign bus.rdata_b     = r_rdata_b;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data    = r_ram_data;
  assign bus.ram_wren    = r_ram_wren;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram32x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram32x4_arbiter
// Brief    : Self-checking bench for ram32x4_arbiter with a behavioural ram32x4.
// Revision : 1.0
// ============================================================================
module tb_ram32x4_arbiter;

  logic clock;
  logic resetn;

  ram32x4_arbiter_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  ram32x4_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ram32x4: registered address/data/wren, q one cycle after the address is captured.
  logic [3:0] mem [0:31];
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  typedef struct {
    bit         b;
    bit         wr;
    logic [4:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit         b;
    bit         wr;
    logic [3:0] rdata;
  } sb_t;

  int         checks   = 0;
  int         failures = 0;
  sb_t        sbq[$];
  sb_t        mon_e;
  logic [3:0] trk_a = 4'h0;
  logic [3:0] trk_b = 4'h0;
  vec_t       tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every ack is matched against the oldest scoreboard entry.
  always @(negedge clock) begin
    if (resetn && (bus.ack_a || bus.ack_b)) begin
      chk("ack_exclusive", 32'(bus.ack_a & bus.ack_b), 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'({bus.ack_b, bus.ack_a}), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_port", 32'(bus.ack_b), 32'(mon_e.b));
        if (!mon_e.wr) begin
          if (mon_e.b) trk_b = mon_e.rdata;
          else         trk_a = mon_e.rdata;
        end
        chk("rdata_a", 32'(bus.rdata_a), 32'(trk_a));
        chk("rdata_b", 32'(bus.rdata_b), 32'(trk_b));
        chk("busy_in_ack", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic drive(input bit b, input bit wr, input logic [4:0] a, input logic [3:0] wd);
    if (b) begin
      bus.wr_b = wr; bus.addr_b = a; bus.wdata_b = wd; bus.req_b = 1'b1;
    end else begin
      bus.wr_a = wr; bus.addr_a = a; bus.wdata_a = wd; bus.req_a = 1'b1;
    end
  endtask

  task automatic set_req(input bit b, input logic v);
    if (b) bus.req_b = v;
    else   bus.req_a = v;
  endtask

  // Waits for this requester's ack, checks cycles elapsed, then drops req after the ack cycle.
  task automatic wait_ack(input bit b, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(posedge clock); #1;
      n = i;
      if (b ? bus.ack_b : bus.ack_a) got = 1'b1;
    end
    if (!got) chk(b ? "ack_b_timeout" : "ack_a_timeout", 32'd0, 32'd1);
    else      chk(b ? "latency_b" : "latency_a", 32'(n), 32'(exp_lat));
    @(posedge clock); #1;
    set_req(b, 1'b0);
  endtask

  task automatic do_txn(input bit b, input bit wr, input logic [4:0] a,
                        input logic [3:0] wd, input logic [3:0] er);
    sb_t e;
    e.b = b; e.wr = wr; e.rdata = er;
    sbq.push_back(e);
    drive(b, wr, a, wd);
    @(posedge clock); #1;
    chk("issue_wren", 32'(bus.ram_wren), 32'(wr));
    chk("issue_addr", 32'(bus.ram_address), 32'(a));
    if (wr) chk("issue_data", 32'(bus.ram_data), 32'(wd));
    chk("issue_busy", 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    chk("wren_drop", 32'(bus.ram_wren), 32'd0);
    wait_ack(b, wr ? 1 : 2);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    sbq.delete();
    trk_a = 4'h0;
    trk_b = 4'h0;
    @(posedge clock); #1;
    chk("reset_outputs", 32'({bus.ack_a, bus.ack_b, bus.rdata_a, bus.rdata_b,
                              bus.ram_address, bus.ram_data, bus.ram_wren, bus.busy}), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
`ifdef RAM_ARB_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      @(posedge clock); #1;
      chk("clr_wren", 32'(bus.ram_wren), 32'd1);
      chk("clr_addr", 32'(bus.ram_address), 32'(i));
      chk("clr_data", 32'(bus.ram_data), 32'd0);
      chk("clr_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clock); #1;
    chk("clr_end_wren", 32'(bus.ram_wren), 32'd0);
    chk("clr_end_busy", 32'(bus.busy), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.req_a = 1'b0; bus.wr_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.wr_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

    //            b     wr    addr    wdata  exp_rdata
    tbl[0] = '{1'b0, 1'b1, 5'd5,  4'hA, 4'h0};
    tbl[1] = '{1'b0, 1'b0, 5'd5,  4'h0, 4'hA};
    tbl[2] = '{1'b1, 1'b1, 5'd7,  4'h3, 4'h0};
    tbl[3] = '{1'b1, 1'b0, 5'd7,  4'h0, 4'h3};
    tbl[4] = '{1'b0, 1'b1, 5'd31, 4'hF, 4'h0};
    tbl[5] = '{1'b1, 1'b0, 5'd31, 4'h0, 4'hF};
    tbl[6] = '{1'b0, 1'b0, 5'd7,  4'h0, 4'h3};
    tbl[7] = '{1'b1, 1'b1, 5'd0,  4'h6, 4'h0};
    tbl[8] = '{1'b0, 1'b0, 5'd0,  4'h0, 4'h6};

    apply_reset();

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].b, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);

    // B streams reads of address 7 with A idle except one write in between.
    do_txn(1'b1, 1'b0, 5'd7, 4'h0, 4'h3);
    do_txn(1'b1, 1'b0, 5'd7, 4'h0, 4'h3);
    do_txn(1'b0, 1'b1, 5'd7, 4'hC, 4'h0);
    do_txn(1'b1, 1'b0, 5'd7, 4'h0, 4'hC);
    do_txn(1'b1, 1'b0, 5'd7, 4'h0, 4'hC);

    // Simultaneous requests straight after reset: A wins, B follows at once.
    apply_reset();
    sbq.push_back('{1'b0, 1'b1, 4'h0});
    sbq.push_back('{1'b1, 1'b1, 4'h0});
    drive(1'b0, 1'b1, 5'd3, 4'h3);
    drive(1'b1, 1'b1, 5'd4, 4'h4);
    fork
      wait_ack(1'b0, 3);
      wait_ack(1'b1, 6);
    join
    do_txn(1'b0, 1'b0, 5'd3, 4'h0, 4'h3);
    do_txn(1'b1, 1'b0, 5'd4, 4'h0, 4'h4);
    // Last served is now B; serve A alone so the next tie goes to B.
    do_txn(1'b0, 1'b0, 5'd4, 4'h0, 4'h4);
    sbq.push_back('{1'b1, 1'b1, 4'h0});
    sbq.push_back('{1'b0, 1'b1, 4'h0});
    drive(1'b0, 1'b1, 5'd10, 4'h1);
    drive(1'b1, 1'b1, 5'd11, 4'h2);
    fork
      wait_ack(1'b1, 3);
      wait_ack(1'b0, 6);
    join
    do_txn(1'b1, 1'b0, 5'd10, 4'h0, 4'h1);
    do_txn(1'b0, 1'b0, 5'd11, 4'h0, 4'h2);

    // Reset while a write sits in ISSUE: wren falls at once and no ack follows.
    do_txn(1'b0, 1'b1, 5'd9, 4'h2, 4'h0);
    do_txn(1'b0, 1'b0, 5'd9, 4'h0, 4'h2);
    drive(1'b0, 1'b1, 5'd9, 4'hD);
    @(posedge clock); #1;
    chk("abort_issue_wren", 32'(bus.ram_wren), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_wren", 32'(bus.ram_wren), 32'd0);
    chk("abort_outputs", 32'({bus.ack_a, bus.ack_b, bus.busy, bus.rdata_a, bus.rdata_b}), 32'd0);
    set_req(1'b0, 1'b0);
    apply_reset();
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_no_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    end
`ifdef RAM_ARB_CLEAR_EN
    do_txn(1'b0, 1'b0, 5'd9, 4'h0, 4'h0);
`else
    do_txn(1'b0, 1'b0, 5'd9, 4'h0, 4'h2);
`endif

`ifdef RAM_ARB_CLEAR_EN
    // B read of 31 held through reset release: served only after the clear.
    do_txn(1'b0, 1'b1, 5'd31, 4'hF, 4'h0);
    drive(1'b1, 1'b0, 5'd31, 4'h0);
    apply_reset();
    sbq.push_back('{1'b1, 1'b0, 4'h0});
    wait_ack(1'b1, 4);
`endif

    repeat (2) @(posedge clock);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
